// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: tracks DEPTH in-flight producers past EX, forwards
// their results to NRD consumer ports, stalls on pending loads, and retires to the register file.
module fwd_scoreboard #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 3,
  parameter int NRD   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                adv,
  input  logic                iss_valid,
  input  logic                iss_wen,
  input  logic [4:0]          iss_rd,
  input  logic                iss_rdy,
  input  logic [XLEN-1:0]     iss_data,
  input  logic                ld_valid,
  input  logic [XLEN-1:0]     ld_data,
  input  logic [5*NRD-1:0]    rs_addr,
  input  logic [NRD-1:0]      rs_use,
  output logic [NRD-1:0]      fwd_hit,
  output logic [XLEN*NRD-1:0] fwd_data,
  output logic                stall,
  output logic                ret_block,
  output logic                ret_valid,
  output logic [4:0]          ret_rd,
  output logic [XLEN-1:0]     ret_data,
  output logic [15:0]         stall_cnt,
  output logic                ld_err
);

  logic [DEPTH-1:0] valid_reg, wen_reg, rdy_reg;
  logic [4:0]       rd_reg   [DEPTH];
  logic [XLEN-1:0]  data_reg [DEPTH];

  logic [DEPTH-1:0] pend, fill_sel, fill_hit, rdy_f;
  logic [XLEN-1:0]  data_f [DEPTH];
  logic             fill_any, blk_int, shift, stall_int;
  logic [NRD-1:0]   hit_int, port_blk;
  logic [XLEN-1:0]  pdata_int [NRD];
  logic [15:0]      stall_cnt_reg;
  logic             ld_err_reg;

  assign pend = valid_reg & wen_reg & ~rdy_reg;

  // The oldest pending load is the one whose data comes back first.
  always_comb begin
    logic found;
    found    = 1'b0;
    fill_sel = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      fill_sel[k] = pend[k] & ~found;
      found       = found | pend[k];
    end
  end

  assign fill_any = |pend;
  assign fill_hit = fill_sel & {DEPTH{ld_valid}};
  assign rdy_f    = rdy_reg | fill_hit;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_fill
      assign data_f[gi] = fill_hit[gi] ? ld_data : data_reg[gi];
    end
  endgenerate

  assign blk_int = pend[DEPTH-1] & ~fill_hit[DEPTH-1];
  assign shift   = adv & ~blk_int;

  // Per-port match: scan oldest to youngest so the youngest match wins.
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_port
      logic [4:0] addr;
      assign addr = rs_addr[gi*5 +: 5];
      always_comb begin
        hit_int[gi]   = 1'b0;
        port_blk[gi]  = 1'b0;
        pdata_int[gi] = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
          if (rs_use[gi] && addr != 5'd0 && valid_reg[k] && wen_reg[k] && rd_reg[k] == addr) begin
            hit_int[gi]   = rdy_f[k];
            port_blk[gi]  = ~rdy_f[k];
            pdata_int[gi] = rdy_f[k] ? data_f[k] : '0;
          end
        end
      end
      assign fwd_hit[gi]                = hit_int[gi] & ~rst;
      assign fwd_data[gi*XLEN +: XLEN]  = rst ? '0 : pdata_int[gi];
    end
  endgenerate

  assign stall_int = iss_valid & (|port_blk);
  assign stall     = stall_int & ~rst;
  assign ret_block = blk_int & ~rst;
  assign ret_valid = ~rst & shift & valid_reg[DEPTH-1] & wen_reg[DEPTH-1];
  assign ret_rd    = ret_valid ? rd_reg[DEPTH-1] : 5'd0;
  assign ret_data  = ret_valid ? data_f[DEPTH-1] : '0;

  // Slot 0 takes the EX instruction; every other slot takes its younger neighbour.
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic            src_valid, src_wen, src_rdy;
      logic [4:0]      src_rd;
      logic [XLEN-1:0] src_data;
      if (gi == 0) begin : g_head
        assign src_valid = iss_valid & ~stall_int;
        assign src_wen   = iss_wen & (iss_rd != 5'd0);
        assign src_rd    = iss_rd;
        assign src_rdy   = iss_rdy;
        assign src_data  = iss_data;
      end else begin : g_body
        assign src_valid = valid_reg[gi-1];
        assign src_wen   = wen_reg[gi-1];
        assign src_rd    = rd_reg[gi-1];
        assign src_rdy   = rdy_f[gi-1];
        assign src_data  = data_f[gi-1];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg[gi] <= 1'b0;
        end else if (shift) begin
          valid_reg[gi] <= src_valid;
          wen_reg[gi]   <= src_wen;
          rd_reg[gi]    <= src_rd;
          rdy_reg[gi]   <= src_rdy;
          data_reg[gi]  <= src_data;
        end else begin
          rdy_reg[gi]   <= rdy_f[gi];
          data_reg[gi]  <= data_f[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= 16'd0;
      ld_err_reg    <= 1'b0;
    end else begin
      if (stall_int && stall_cnt_reg != 16'hFFFF)
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
      if (ld_valid && !fill_any)
        ld_err_reg <= 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign ld_err    = ld_err_reg;

endmodule
